// File: rtl/serial_subtractor_4_bit.sv
// serial_subtractor_4_bit: bit-serial A-B, LSB first, start/busy/done handshake; ports clk, rst, start, A, B -> D, Bout, busy, done
module serial_subtractor_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_next;
  logic [CW-1:0] count;
  logic borrow, a, b, diff, borrow_next, last;
  always_comb begin
    a           = a_sr[0];
    b           = b_sr[0];
    diff        = a ^ b ^ borrow;
    borrow_next = (~a & b) | (~(a ^ b) & borrow);
    d_next      = {diff, d_sr[WIDTH-1:1]};
    last        = count == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      count  <= '0;
      borrow <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SUB;
          end
        end
        SUB: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= d_next;
          borrow <= borrow_next;
          count  <= count + CW'(1);
          if (last) begin
            D     <= d_next;
            Bout  <= borrow_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_4_bit.sv
// tb_serial_subtractor_4_bit: table vectors, scoreboard and cycle model for serial_subtractor_4_bit
module tb_serial_subtractor_4_bit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] A = '0, B = '0, D;
  logic Bout, busy, done;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [3:0] a, b, d; logic bo;} vec_t;
  typedef struct {logic [3:0] d; logic bo;} res_t;
  vec_t v[8];
  res_t q[$];
  int ph = 0;
  logic [3:0] hold_d = '0;
  logic hold_bo = 1'b0;
  logic armed = 1'b0;

  serial_subtractor_4_bit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .D(D), .Bout(Bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // independent cycle model: ph 0 idle, 1..4 subtracting, 5 result cycle
  always @(posedge clk) begin
    if (rst) begin
      ph = 0;
      q.delete();
      hold_d = '0;
      hold_bo = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        q.push_back('{d: 4'(A - B), bo: A < B});
        ph = 1;
      end
    end else
      ph = (ph == 5) ? 0 : ph + 1;
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", int'(busy), int'(ph != 0));
      chk("done", int'(done), int'(ph == 5));
      if (ph == 5 && q.size() > 0) begin
        res_t r;
        r = q.pop_front();
        hold_d = r.d;
        hold_bo = r.bo;
      end
      chk("D", int'(D), int'(hold_d));
      chk("Bout", int'(Bout), int'(hold_bo));
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int busy_n, output logic got);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = ~b;
    busy_n = 0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (busy) busy_n++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    int bn;
    logic got;
    v[0] = '{4'd9, 4'd5, 4'd4, 1'b0};
    v[1] = '{4'd5, 4'd9, 4'hC, 1'b1};
    v[2] = '{4'd0, 4'd1, 4'd15, 1'b1};
    v[3] = '{4'd15, 4'd15, 4'd0, 1'b0};
    v[4] = '{4'd0, 4'd0, 4'd0, 1'b0};
    v[5] = '{4'd15, 4'd0, 4'd15, 1'b0};
    v[6] = '{4'd0, 4'd15, 4'd1, 1'b1};
    v[7] = '{4'd7, 4'd8, 4'd15, 1'b1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_D", int'(D), 0);
    chk("reset_busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].a, v[i].b, bn, got);
      chk("vec_done_seen", int'(got), 1);
      chk("vec_D", int'(D), int'(v[i].d));
      chk("vec_Bout", int'(Bout), int'(v[i].bo));
      chk("vec_busy_cycles", bn, 5);
    end
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("backtoback_drained", q.size(), 0);
    A = 4'd9;
    B = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_D", int'(D), 0);
    chk("rst_mid_Bout", int'(Bout), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    repeat (8) @(negedge clk);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), bn, got);
        chk("exh_done_seen", int'(got), 1);
        chk("exh_D", int'(D), (a - b) & 15);
        chk("exh_Bout", int'(Bout), int'(a < b));
      end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
